// File: rtl/decoder_2_to_4_hold.sv
// decoder_2_to_4_hold: registered 2-to-4 decoder with valid/ready intake.
// Each accepted code word drives its one-hot line for HOLD_CYCLES enabled
// cycles; a new word may be accepted on the final hold cycle for gapless
// back-to-back operation.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  code word on A1/A0 is valid
//   in_ready  block can accept a word this cycle
//   A0, A1    code bits, captured only at acceptance
//   EN        drive enable; low pauses the hold and blanks outputs
//   Y0..Y3    one-hot decoded lines
//   busy      a word is held (DRIVE state)
//   done      pulse on the final hold cycle of a word
//   count     completed-word counter, wrapping
module decoder_2_to_4_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A0,
  input  logic             A1,
  input  logic             EN,
  output logic             Y0,
  output logic             Y1,
  output logic             Y2,
  output logic             Y3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        code;
  logic [HOLD_W-1:0] hold;
  logic              drive_en;
  logic              final_cyc;

  // Outputs decode from registered state/code; EN only gates them.
  assign drive_en  = (state == DRIVE) && EN;
  assign final_cyc = drive_en && (hold == HOLD_LAST);

  assign busy     = (state == DRIVE);
  assign done     = final_cyc;
  assign in_ready = (state == IDLE) || final_cyc;

  assign Y0 = drive_en && (code == 2'd0);
  assign Y1 = drive_en && (code == 2'd1);
  assign Y2 = drive_en && (code == 2'd2);
  assign Y3 = drive_en && (code == 2'd3);

  // State, captured code, hold counter and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code  <= 2'b00;
      hold  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= DRIVE;
            code  <= {A1, A0};
            hold  <= '0;
          end
        end
        DRIVE: begin
          // EN low freezes everything; the word resumes where it left off.
          if (EN) begin
            if (hold == HOLD_LAST) begin
              count <= count + CNT_W'(1);
              hold  <= '0;
              if (in_valid) begin
                code <= {A1, A0};
              end else begin
                state <= IDLE;
              end
            end else begin
              hold <= hold + HOLD_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_2_to_4_hold.sv
// Directed self-checking bench for decoder_2_to_4_hold.
// Main instance: HOLD_CYCLES=4, CNT_W=8. Wrap instance: HOLD_CYCLES=1, CNT_W=2.
module tb_decoder_2_to_4_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;

  logic       in_valid, in_ready, a0, a1;
  logic       y0, y1, y2, y3, busy, done;
  logic [7:0] count;

  logic       w_valid, w_ready;
  logic       w_y0, w_y1, w_y2, w_y3, w_busy, w_done;
  logic [1:0] w_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_2_to_4_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A0(a0), .A1(a1), .EN(en),
    .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3),
    .busy(busy), .done(done), .count(count)
  );

  decoder_2_to_4_hold #(.HOLD_CYCLES(1), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready),
    .A0(1'b0), .A1(1'b0), .EN(en),
    .Y0(w_y0), .Y1(w_y1), .Y2(w_y2), .Y3(w_y3),
    .busy(w_busy), .done(w_done), .count(w_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ylines();
    return {y3, y2, y1, y0};
  endfunction

  // Check one cycle of the main instance against expected outputs.
  task automatic expect_cycle(input string tag, input logic [3:0] y, input logic b,
                              input logic d, input logic r);
    check({tag, ".y"}, 32'(ylines()), 32'(y));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".ready"}, 32'(in_ready), 32'(r));
  endtask

  // Send one word from IDLE and follow its full hold with EN high.
  task automatic send_word(input logic [1:0] c);
    logic [7:0]  base;
    logic [3:0]  onehot;
    base   = count;
    onehot = 4'b0001 << c;
    check("send.pre_ready", 32'(in_ready), 32'd1);
    {a1, a0} = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    {a1, a0} = ~c;  // must be ignored while held
    for (int i = 0; i < 4; i++) begin
      expect_cycle($sformatf("word%0d.c%0d", c, i + 1), onehot, 1'b1, i == 3, i == 3);
      check("word.count_hold", 32'(count), 32'(base));
      tick();
    end
    expect_cycle("word.idle", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("word.count_inc", 32'(count), 32'(base + 8'd1));
  endtask

  initial begin
    logic [7:0] base;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; a0 = 1'b0; a1 = 1'b0; w_valid = 1'b0;

    // Reset and idle stability.
    tick(); tick();
    expect_cycle("reset", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("reset.count", 32'(count), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_cycle("idle", 4'b0000, 1'b0, 1'b0, 1'b1);
      check("idle.count", 32'(count), 32'd0);
    end

    // Reset wins over a simultaneous handshake.
    rst = 1'b1; in_valid = 1'b1; {a1, a0} = 2'b11;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    expect_cycle("rst_vs_hs", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    expect_cycle("rst_vs_hs.after", 4'b0000, 1'b0, 1'b0, 1'b1);

    // All four codes with idle gaps.
    for (int c = 0; c < 4; c++) begin
      send_word(2'(c));
      tick(); tick();
    end
    check("decode.count", 32'(count), 32'd4);

    // Back-to-back 11 then 01 with in_valid held high.
    base = count;
    {a1, a0} = 2'b11; in_valid = 1'b1;
    tick();
    {a1, a0} = 2'b01;  // ignored until the final cycle
    for (int i = 0; i < 4; i++) begin
      expect_cycle($sformatf("b2b.w1c%0d", i + 1), 4'b1000, 1'b1, i == 3, i == 3);
      tick();
    end
    in_valid = 1'b0;
    check("b2b.count1", 32'(count), 32'(base + 8'd1));
    for (int i = 0; i < 4; i++) begin
      expect_cycle($sformatf("b2b.w2c%0d", i + 1), 4'b0010, 1'b1, i == 3, i == 3);
      tick();
    end
    expect_cycle("b2b.idle", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("b2b.count2", 32'(count), 32'(base + 8'd2));

    // EN pause after the 2nd drive cycle.
    tick();
    base = count;
    {a1, a0} = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_cycle("pause.c1", 4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    expect_cycle("pause.c2", 4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_cycle($sformatf("pause.off%0d", i + 1), 4'b0000, 1'b1, 1'b0, 1'b0);
      tick();
    end
    en = 1'b1;
    #1;
    expect_cycle("pause.c3", 4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    expect_cycle("pause.c4", 4'b0100, 1'b1, 1'b1, 1'b1);
    check("pause.count_hold", 32'(count), 32'(base));
    tick();
    expect_cycle("pause.idle", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("pause.count", 32'(count), 32'(base + 8'd1));

    // Reset on the 2nd drive cycle aborts the word.
    tick();
    base = count;
    {a1, a0} = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_cycle("abort.c1", 4'b0010, 1'b1, 1'b0, 1'b0);
    tick();
    expect_cycle("abort.c2", 4'b0010, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_cycle("abort.after", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("abort.count", 32'(count), 32'd0);
    check("abort.base_nonzero", 32'(base), 32'd7);
    tick();
    expect_cycle("abort.idle", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Counter wrap with HOLD_CYCLES=1, CNT_W=2: five back-to-back words.
    w_valid = 1'b1;
    tick();
    for (int j = 1; j <= 5; j++) begin
      check("wrap.y0", 32'({w_y3, w_y2, w_y1, w_y0}), 32'd1);
      check("wrap.done", 32'(w_done), 32'd1);
      check("wrap.ready", 32'(w_ready), 32'd1);
      if (j == 5) w_valid = 1'b0;
      tick();
      check($sformatf("wrap.count%0d", j), 32'(w_count), 32'(j % 4));
    end
    check("wrap.idle_busy", 32'(w_busy), 32'd0);
    check("wrap.idle_y", 32'({w_y3, w_y2, w_y1, w_y0}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
